// File: rtl/cpu_defs.sv
// Shared CPU definitions: boot/exception vectors, fetch step and fetch FSM encoding.
package cpu_defs;

    localparam logic [31:0] RESET_VECTOR = 32'hbfc00000;
    localparam logic [31:0] EXC_VECTOR   = 32'hbfc00380;
    localparam int unsigned STEP         = 4;

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_e;

endpackage

// File: rtl/pc_redirect_buf.sv
// Holds a redirect target that arrives while a fetch request is outstanding.
// A buffered flush is never overwritten by a later branch.
module pc_redirect_buf #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hold_i,        // request pending, not accepted this cycle
    input  logic             clear_i,       // buffer consumed or superseded
    input  logic             flush_i,
    input  logic [WIDTH-1:0] flush_pc_i,
    input  logic             branch_i,
    input  logic [WIDTH-1:0] branch_pc_i,
    output logic             pend_valid_o,
    output logic             pend_is_flush_o,
    output logic [WIDTH-1:0] pend_pc_o
);

    logic             pend_valid_q, pend_valid_d;
    logic             pend_is_flush_q, pend_is_flush_d;
    logic [WIDTH-1:0] pend_pc_q, pend_pc_d;

    // Capture/overwrite rules for the pending redirect
    always_comb begin
        pend_valid_d    = pend_valid_q;
        pend_is_flush_d = pend_is_flush_q;
        pend_pc_d       = pend_pc_q;
        if (clear_i) begin
            pend_valid_d    = 1'b0;
            pend_is_flush_d = 1'b0;
        end else if (hold_i) begin
            if (flush_i) begin
                pend_valid_d    = 1'b1;
                pend_is_flush_d = 1'b1;
                pend_pc_d       = flush_pc_i;
            end else if (branch_i && !pend_is_flush_q) begin
                pend_valid_d    = 1'b1;
                pend_pc_d       = branch_pc_i;
            end
        end
    end

    // Buffer registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_valid_q    <= 1'b0;
            pend_is_flush_q <= 1'b0;
            pend_pc_q       <= '0;
        end else begin
            pend_valid_q    <= pend_valid_d;
            pend_is_flush_q <= pend_is_flush_d;
            pend_pc_q       <= pend_pc_d;
        end
    end

    assign pend_valid_o    = pend_valid_q;
    assign pend_is_flush_o = pend_is_flush_q;
    assign pend_pc_o       = pend_pc_q;

endmodule

// File: rtl/pc_fetch_ctrl.sv
// IF-stage PC register and instruction-address handshake controller.
// Optional feature macro: PC_ALIGN_CHECK_EN (misaligned-fetch detection, inst_adel_o).
module pc_fetch_ctrl #(
    parameter int unsigned     WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(cpu_defs::RESET_VECTOR),
    parameter int unsigned     STEP         = cpu_defs::STEP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall_i,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] flush_pc_i,
    input  logic             branch_i,
    input  logic [WIDTH-1:0] branch_pc_i,
    output logic             inst_req_o,
    output logic [WIDTH-1:0] inst_addr_o,
    input  logic             inst_addr_ok_i,
    output logic [WIDTH-1:0] pc_o,
    output logic             inst_adel_o
);

    import cpu_defs::*;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] next_pc;
    logic             misaligned;
    logic             req;
    logic             hs;
    logic             direct_load;
    logic             pend_valid;
    logic             pend_is_flush;
    logic [WIDTH-1:0] pend_pc;

`ifdef PC_ALIGN_CHECK_EN
    assign misaligned = (state_q == S_REQ) && (pc_q[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    assign req         = (state_q == S_REQ) && !misaligned;
    assign hs          = req && inst_addr_ok_i;
    // Redirects bypass the buffer when no request is outstanding
    assign direct_load = (state_q == S_WAIT) || misaligned;

    pc_redirect_buf #(
        .WIDTH (WIDTH)
    ) u_redirect_buf (
        .clk             (clk),
        .rst             (rst),
        .hold_i          (req && !inst_addr_ok_i),
        .clear_i         (hs || (direct_load && flush_i)),
        .flush_i         (flush_i),
        .flush_pc_i      (flush_pc_i),
        .branch_i        (branch_i),
        .branch_pc_i     (branch_pc_i),
        .pend_valid_o    (pend_valid),
        .pend_is_flush_o (pend_is_flush),
        .pend_pc_o       (pend_pc)
    );

    // Next fetch address used on a handshake
    always_comb begin
        if (flush_i) begin
            next_pc = flush_pc_i;
        end else if (pend_valid) begin
            next_pc = pend_pc;
        end else if (branch_i) begin
            next_pc = branch_pc_i;
        end else begin
            next_pc = pc_q + WIDTH'(STEP);
        end
    end

    // PC update: advance on handshake, direct redirect otherwise
    always_comb begin
        pc_d = pc_q;
        if (hs) begin
            pc_d = next_pc;
        end else if (direct_load) begin
            if (flush_i) begin
                pc_d = flush_pc_i;
            end else if ((state_q == S_WAIT) && branch_i) begin
                pc_d = branch_pc_i;
            end
        end
    end

    // State and PC registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_BOOT;
            pc_q    <= RESET_VECTOR;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    // Next-state logic; S_REQ only leaves on a handshake so the address stays stable
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_BOOT:  state_d = stall_i ? S_WAIT : S_REQ;
            S_REQ:   if (hs) state_d = stall_i ? S_WAIT : S_REQ;
            S_WAIT:  if (!stall_i) state_d = S_REQ;
            default: state_d = S_BOOT;
        endcase
    end

    // Outputs depend on registered state and pc only
    always_comb begin
        inst_req_o  = req;
        inst_addr_o = pc_q;
        pc_o        = pc_q;
        inst_adel_o = misaligned;
    end

    logic unused_pend_is_flush;
    assign unused_pend_is_flush = pend_is_flush;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Table-driven bench for pc_fetch_ctrl plus hand-written corner sequences.
module tb_pc_fetch_ctrl;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        flush;
    logic [31:0] flush_pc;
    logic        branch;
    logic [31:0] branch_pc;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic [31:0] pc;
    logic        inst_adel;

    int checks;
    int failures;

    typedef struct {
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        stall;
        logic        ok;
        logic        flush;
        logic [31:0] fpc;
        logic        branch;
        logic [31:0] bpc;
    } vec_t;

    vec_t vecs[$];

    pc_fetch_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .stall_i        (stall),
        .flush_i        (flush),
        .flush_pc_i     (flush_pc),
        .branch_i       (branch),
        .branch_pc_i    (branch_pc),
        .inst_req_o     (inst_req),
        .inst_addr_o    (inst_addr),
        .inst_addr_ok_i (inst_addr_ok),
        .pc_o           (pc),
        .inst_adel_o    (inst_adel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic er, input logic [31:0] ea, input logic st, input logic ok,
                       input logic fl, input logic [31:0] fpc, input logic br,
                       input logic [31:0] bpc);
        vec_t v;
        v.exp_req = er; v.exp_addr = ea; v.stall = st; v.ok = ok;
        v.flush = fl; v.fpc = fpc; v.branch = br; v.bpc = bpc;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic st, input logic ok, input logic fl, input logic [31:0] fpc,
                         input logic br, input logic [31:0] bpc);
        stall = st; inst_addr_ok = ok; flush = fl; flush_pc = fpc;
        branch = br; branch_pc = bpc;
    endtask

    task automatic check_out(input string tag, input logic er, input logic [31:0] ea,
                             input logic eadel);
        check({tag, ".req"}, {31'd0, inst_req}, {31'd0, er});
        check({tag, ".addr"}, inst_addr, ea);
        check({tag, ".pc"}, pc, ea);
        check({tag, ".adel"}, {31'd0, inst_adel}, {31'd0, eadel});
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b1;
        drive(0, 0, 0, 32'h0, 0, 32'h0);

        // exp_req exp_addr      stall ok flush fpc            branch bpc
        add(0, 32'hbfc00000, 0, 1, 0, 32'h0,         0, 32'h0);        // S_BOOT
        add(1, 32'hbfc00000, 0, 1, 0, 32'h0,         0, 32'h0);
        add(1, 32'hbfc00004, 0, 1, 0, 32'h0,         0, 32'h0);
        add(1, 32'hbfc00008, 0, 0, 0, 32'h0,         1, 32'hbfc00100); // buffered branch
        add(1, 32'hbfc00008, 0, 0, 0, 32'h0,         0, 32'h0);
        add(1, 32'hbfc00008, 0, 0, 0, 32'h0,         0, 32'h0);
        add(1, 32'hbfc00008, 0, 1, 0, 32'h0,         0, 32'h0);
        add(1, 32'hbfc00100, 0, 0, 0, 32'h0,         1, 32'h00000100);
        add(1, 32'hbfc00100, 0, 0, 1, 32'hbfc00380,  0, 32'h0);
        add(1, 32'hbfc00100, 0, 0, 0, 32'h0,         1, 32'h00000200); // must not override flush
        add(1, 32'hbfc00100, 0, 1, 0, 32'h0,         0, 32'h0);
        add(1, 32'hbfc00380, 0, 1, 0, 32'h0,         0, 32'h0);        // buffer cleared -> +4
        add(1, 32'hbfc00384, 1, 0, 0, 32'h0,         0, 32'h0);        // stall while pending
        add(1, 32'hbfc00384, 1, 0, 0, 32'h0,         0, 32'h0);
        add(1, 32'hbfc00384, 1, 1, 0, 32'h0,         0, 32'h0);        // handshake -> S_WAIT
        add(0, 32'hbfc00388, 1, 0, 0, 32'h0,         0, 32'h0);
        add(0, 32'hbfc00388, 0, 0, 0, 32'h0,         0, 32'h0);
        add(1, 32'hbfc00388, 0, 0, 0, 32'h0,         1, 32'h00000500); // pending branch
        add(1, 32'hbfc00388, 0, 1, 1, 32'hfffffffc,  1, 32'h00000600); // flush wins all
        add(1, 32'hfffffffc, 0, 1, 0, 32'h0,         0, 32'h0);        // wraps
        add(1, 32'h00000000, 0, 1, 0, 32'h0,         0, 32'h0);
        add(1, 32'h00000004, 1, 1, 0, 32'h0,         0, 32'h0);
        add(0, 32'h00000008, 1, 0, 0, 32'h0,         1, 32'h00000040); // direct branch in S_WAIT
        add(0, 32'h00000040, 1, 0, 1, 32'hbfc00380,  1, 32'h00000080); // flush beats branch
        add(0, 32'hbfc00380, 0, 0, 0, 32'h0,         0, 32'h0);
        add(1, 32'hbfc00380, 0, 1, 0, 32'h0,         0, 32'h0);
        add(1, 32'hbfc00384, 0, 0, 0, 32'h0,         0, 32'h0);

        // Async reset asserted: outputs at reset values before any edge
        #2;
        check_out("reset", 1'b0, 32'hbfc00000, 1'b0);
        #10 rst = 1'b0;  // released between edges

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].stall, vecs[i].ok, vecs[i].flush, vecs[i].fpc,
                  vecs[i].branch, vecs[i].bpc);
            check_out($sformatf("vec%0d", i), vecs[i].exp_req, vecs[i].exp_addr, 1'b0);
            @(posedge clk);
            #1;
        end

        // Misaligned branch target taken on a handshake
        drive(0, 1, 0, 32'h0, 1, 32'h00000102);
        check_out("mis_pre", 1'b1, 32'hbfc00384, 1'b0);
        @(posedge clk); #1;
`ifdef PC_ALIGN_CHECK_EN
        drive(0, 1, 0, 32'h0, 0, 32'h0);
        check_out("adel0", 1'b0, 32'h00000102, 1'b1);
        @(posedge clk); #1;
        drive(0, 1, 1, 32'hbfc00380, 0, 32'h0);
        check_out("adel1", 1'b0, 32'h00000102, 1'b1);
        @(posedge clk); #1;
        drive(0, 0, 0, 32'h0, 0, 32'h0);
        check_out("adel_flush", 1'b1, 32'hbfc00380, 1'b0);
`else
        drive(0, 1, 0, 32'h0, 0, 32'h0);
        check_out("mis_issue", 1'b1, 32'h00000102, 1'b0);
        @(posedge clk); #1;
        drive(0, 0, 0, 32'h0, 0, 32'h0);
        check_out("mis_next", 1'b1, 32'h00000106, 1'b0);
`endif

        // Reset mid-request drops the request without a clock edge
        #2 rst = 1'b1;
        #1;
        check_out("mid_rst", 1'b0, 32'hbfc00000, 1'b0);
        @(posedge clk); #1;
        check_out("rst_hold", 1'b0, 32'hbfc00000, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
